// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// uart_tx_fifo : FIFO-buffered UART transmitter paced by an external bit tick
// Rev 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tick,
   input  logic [DATA_BITS-1:0]          in_data,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          tx,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int IDX_W = $clog2(DATA_BITS);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   state_t               state_q, state_d;
   logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
   logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]     count_q;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
   logic                 stop_cnt_q, stop_cnt_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 push, pop, fifo_empty;
   logic [DATA_BITS-1:0] head;

   assign in_ready   = (count_q < CNT_W'(FIFO_DEPTH));
   assign push       = in_valid && in_ready;
   assign fifo_empty = (count_q == '0);
   assign head       = mem_q[rd_ptr_q];
   assign fifo_count = count_q;
   assign tx         = tx_q;
   assign busy       = (state_q != S_IDLE) || !fifo_empty;

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end

   // Pointers wrap naturally because FIFO_DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         shift_q    <= '0;
         bit_idx_q  <= '0;
         stop_cnt_q <= 1'b0;
         par_q      <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         shift_q    <= shift_d;
         bit_idx_q  <= bit_idx_d;
         stop_cnt_q <= stop_cnt_d;
         par_q      <= par_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      shift_d    = shift_q;
      bit_idx_d  = bit_idx_q;
      stop_cnt_d = stop_cnt_q;
      par_d      = par_q;
      tx_d       = tx_q;
      pop        = 1'b0;
      if (tick) begin
         unique case (state_q)
            S_IDLE: begin
               if (!fifo_empty) begin
                  pop     = 1'b1;
                  shift_d = head;
                  par_d   = ^head;
                  tx_d    = 1'b0;
                  state_d = S_START;
               end else begin
                  tx_d = 1'b1;
               end
            end
            S_START: begin
               tx_d      = shift_q[0];
               bit_idx_d = '0;
               state_d   = S_DATA;
            end
            S_DATA: begin
               if (bit_idx_q != IDX_W'(DATA_BITS - 1)) begin
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + IDX_W'(1);
               end else if (PARITY_EN != 0) begin
                  tx_d    = par_q ^ PARITY_ODD[0];
                  state_d = S_PARITY;
               end else begin
                  tx_d       = 1'b1;
                  stop_cnt_d = 1'b0;
                  state_d    = S_STOP;
               end
            end
            S_PARITY: begin
               tx_d       = 1'b1;
               stop_cnt_d = 1'b0;
               state_d    = S_STOP;
            end
            S_STOP: begin
               if (stop_cnt_q != 1'(STOP_BITS - 1)) begin
                  stop_cnt_d = 1'b1;
               end else if (!fifo_empty) begin
                  // Chain straight into the next start bit with no idle gap.
                  pop     = 1'b1;
                  shift_d = head;
                  par_d   = ^head;
                  tx_d    = 1'b0;
                  state_d = S_START;
               end else begin
                  tx_d    = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: begin
               tx_d    = 1'b1;
               state_d = S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_uart_tx_fifo : scoreboard bench for uart_tx_fifo (default, even, odd/2-stop)
// Rev 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

   logic       clk = 1'b0, reset = 1'b1, tick = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0, in_valid_p = 1'b0, in_valid_po = 1'b0;
   logic       in_ready, tx, busy;
   logic       in_ready_p, tx_p, busy_p;
   logic       in_ready_po, tx_po, busy_po;
   logic [2:0] fifo_count, fifo_count_p, fifo_count_po;

   uart_tx_fifo dut (
      .clk(clk), .reset(reset), .tick(tick), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .tx(tx), .busy(busy), .fifo_count(fifo_count));

   uart_tx_fifo #(.PARITY_EN(1)) dut_p (
      .clk(clk), .reset(reset), .tick(tick), .in_data(in_data), .in_valid(in_valid_p),
      .in_ready(in_ready_p), .tx(tx_p), .busy(busy_p), .fifo_count(fifo_count_p));

   uart_tx_fifo #(.PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) dut_po (
      .clk(clk), .reset(reset), .tick(tick), .in_data(in_data), .in_valid(in_valid_po),
      .in_ready(in_ready_po), .tx(tx_po), .busy(busy_po), .fifo_count(fifo_count_po));

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Tick generator: one pulse every 5 clocks, or every clock when forced.
   bit tick_en = 1'b0, tick_force = 1'b1;
   int div = 0;
   initial forever begin
      @(negedge clk);
      tick = tick_force || (tick_en && div == 4);
      div  = (div == 4) ? 0 : div + 1;
   end

   // Scoreboards: words for the default DUT, raw bit streams for parity DUTs.
   logic [7:0] sb[$];
   bit         exp_p[$], exp_po[$];
   int         rx_st = 0, rx_n = 0, rx_done = 0, starts = 0;
   int         tick_idx = 0, last_start = 0, start_gap = 0, cyc = 0, start_cyc = 0;
   logic [7:0] rx_word = 8'h00;

   initial forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (reset) begin
         rx_st = 0;
      end else if (tick) begin
         tick_idx++;
         case (rx_st)
            0: if (tx == 1'b0) begin
                  starts++;
                  start_gap  = tick_idx - last_start;
                  last_start = tick_idx;
                  start_cyc  = cyc;
                  rx_n       = 0;
                  rx_st      = 1;
               end
            1: begin
                  rx_word[rx_n] = tx;
                  rx_n++;
                  if (rx_n == 8) rx_st = 2;
               end
            default: begin
                  check_eq("stop_bit", tx, 1);
                  check_eq("sb_has_entry", sb.size() != 0, 1);
                  if (sb.size() != 0) check_eq("rx_word", rx_word, sb.pop_front());
                  rx_done++;
                  rx_st = 0;
               end
         endcase
         if (exp_p.size() != 0)  check_eq("even_par_bit", tx_p, exp_p.pop_front());
         if (exp_po.size() != 0) check_eq("odd_2stop_bit", tx_po, exp_po.pop_front());
      end
   end

   task automatic wait_tick();
      do @(posedge clk); while (!tick);
   endtask

   task automatic wait_rx(input int target);
      int n = 0;
      while (rx_done < target && n < 2000) begin
         @(posedge clk);
         n++;
      end
      check_eq("rx_wait_in_time", rx_done >= target, 1);
   endtask

   // Leaves in_valid high on return (at the accepting edge); end_push drops it.
   task automatic push(input logic [7:0] w, output int waited);
      @(negedge clk);
      in_data  = w;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 500) begin
         @(negedge clk);
         waited++;
      end
      @(posedge clk);
      if (waited < 500) sb.push_back(w);
   endtask

   task automatic end_push();
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   initial begin
      int w, s0, n, base;
      logic [7:0] pw;

      // 1: reset with ticks pulsing every cycle
      repeat (3) begin
         @(posedge clk); #2;
         check_eq("rst_tx", tx, 1);
         check_eq("rst_in_ready", in_ready, 1);
         check_eq("rst_busy", busy, 0);
         check_eq("rst_count", fifo_count, 0);
      end
      @(negedge clk);
      reset = 1'b0; tick_force = 1'b0; tick_en = 1'b1;
      @(posedge clk); #2;
      check_eq("rel_tx", tx, 1);
      check_eq("rel_busy", busy, 0);
      check_eq("rel_in_ready", in_ready, 1);

      // 2: single 0xA5 frame, 10 bit periods of 5 clocks
      wait_tick();
      push(8'hA5, w);
      end_push();
      base = rx_done;
      wait_rx(base + 1);
      n = 0;
      do begin @(posedge clk); #2; n++; end while (busy && n < 200);
      check_eq("frame_clks", cyc - start_cyc, 50);
      check_eq("post_frame_tx", tx, 1);
      check_eq("post_frame_busy", busy, 0);

      // 3: back-to-back frames
      wait_tick();
      push(8'h00, w);
      push(8'hFF, w);
      end_push();
      check_eq("b2b_count2", fifo_count, 2);
      wait_tick(); #1;
      check_eq("b2b_count1", fifo_count, 1);
      wait_rx(base + 3);
      check_eq("b2b_gap_ticks", start_gap, 10);
      check_eq("b2b_count0", fifo_count, 0);

      // 4: FIFO full with tick held low
      tick_en = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 1; i <= 4; i++) begin
         pw = 8'(i * 8'h11);
         push(pw, w);
         check_eq("fill_no_wait", w, 0);
      end
      @(negedge clk);
      in_data = 8'h55; in_valid = 1'b1;
      check_eq("full_count", fifo_count, 4);
      repeat (3) @(negedge clk);
      check_eq("full_in_ready", in_ready, 0);
      s0 = starts;
      tick_en = 1'b1;
      n = 0;
      while (!in_ready && n < 100) begin @(negedge clk); n++; end
      check_eq("accept_after_pop", starts, s0 + 1);
      @(posedge clk);
      sb.push_back(8'h55);
      end_push();
      wait_rx(base + 8);
      check_eq("full_drain_count", fifo_count, 0);

      // 5: parity variants; odd/2-stop DUT gets two words back to back
      wait_tick();
      @(negedge clk);
      pw = 8'h07;
      in_data = pw; in_valid_p = 1'b1; in_valid_po = 1'b1;
      exp_p.push_back(1'b0);
      for (int i = 0; i < 8; i++) exp_p.push_back(pw[i]);
      exp_p.push_back(^pw);
      exp_p.push_back(1'b1);
      exp_p.push_back(1'b1);
      for (int k = 0; k < 2; k++) begin
         exp_po.push_back(1'b0);
         for (int i = 0; i < 8; i++) exp_po.push_back(pw[i]);
         exp_po.push_back(~^pw);
         exp_po.push_back(1'b1);
         exp_po.push_back(1'b1);
      end
      exp_po.push_back(1'b1);
      @(negedge clk); in_valid_p = 1'b0;
      @(negedge clk); in_valid_po = 1'b0;
      n = 0;
      while ((exp_p.size() != 0 || exp_po.size() != 0) && n < 400) begin @(posedge clk); n++; end
      check_eq("par_stream_done", exp_p.size() + exp_po.size(), 0);
      check_eq("par_busy", busy_p, 0);
      check_eq("par_count", fifo_count_p, 0);
      check_eq("par_ready", in_ready_p, 1);
      check_eq("odd_busy", busy_po, 0);
      check_eq("odd_count", fifo_count_po, 0);
      check_eq("odd_ready", in_ready_po, 1);

      // 6: reset during the third data bit with two words queued
      wait_tick();
      s0 = starts;
      push(8'h3C, w);
      push(8'hC3, w);
      push(8'h5A, w);
      end_push();
      n = 0;
      while (starts == s0 && n < 100) begin @(posedge clk); #2; n++; end
      check_eq("mid_started", starts, s0 + 1);
      repeat (3) wait_tick();
      @(negedge clk);
      check_eq("pre_reset_count", fifo_count, 2);
      reset = 1'b1;
      sb.delete();
      @(posedge clk); #2;
      check_eq("mid_rst_tx", tx, 1);
      check_eq("mid_rst_count", fifo_count, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      s0 = starts;
      repeat (150) @(posedge clk);
      #2;
      check_eq("no_frames_after_rst", starts, s0);
      check_eq("idle_busy", busy, 0);
      check_eq("idle_tx", tx, 1);
      check_eq("sb_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
